// File: rtl/cache_pkg.sv
// cache_pkg: shared state type, block geometry and word-offset rotation for the cache fill controller
// Optional feature macro used by importers: CACHE_FILL_CRIT_WORD_FIRST_EN
package cache_pkg;
  typedef enum logic {IDLE, FILL} fill_state_t;
  localparam int BLOCK_WORDS = 8;
  localparam int WORD_IDX_W = $clog2(BLOCK_WORDS);
  function automatic logic [WORD_IDX_W-1:0] rot_offset(input logic [WORD_IDX_W-1:0] crit, input logic [WORD_IDX_W-1:0] n);
    return crit + n;
  endfunction
endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: sync-clear, enable-increment counter that saturates at MAX
// Ports: clk, rst, i_clr (clear), i_en (increment), o_count, o_sat (count==MAX)
module fill_counter #(
  parameter int MAX = 8,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_sat
);
  assign o_sat = o_count == W'(MAX);
  always_ff @(posedge clk)
    o_count <= (rst || i_clr) ? '0 : (i_en && !o_sat) ? o_count + 1'b1 : o_count;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss fill controller issuing one pipelined read per word and writing returns into the arrays
// Ports: miss_detected/miss_address start a fill; mem_en/mem_addr issue reads; mem_data_valid/mem_data_in
// return words in order; write_data_array/word_index/fill_data and write_tag_array strobe the cache arrays;
// fsm_busy stalls the pipeline. Macro CACHE_FILL_CRIT_WORD_FIRST_EN rotates the word order to start at the missed word.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  localparam int WIW = $clog2(BLOCK_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  mem_data_valid,
  input  logic [15:0]           mem_data_in,
  output logic                  fsm_busy,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [WIW-1:0]        word_index,
  output logic [15:0]           fill_data
);
  import cache_pkg::*;
  fill_state_t r_state;
  logic [ADDR_WIDTH-WIW-2:0] r_tag;
  logic [WIW:0] w_iss, w_ret;
  logic [WIW-1:0] w_iss_off, w_ret_off;
  logic w_iss_sat, w_ret_sat, w_start, w_wr, w_last, w_unused;
  assign w_start = r_state == IDLE && miss_detected;
  assign fsm_busy = r_state == FILL;
  assign mem_en = fsm_busy && !w_iss_sat;
  // a return with nothing outstanding is a protocol error and is dropped
  assign w_wr = fsm_busy && mem_data_valid && w_ret < w_iss;
  assign w_last = w_wr && &w_ret[WIW-1:0];
  assign mem_addr = mem_en ? {r_tag, w_iss_off, 1'b0} : '0;
  assign write_data_array = w_wr;
  assign write_tag_array = w_last;
  assign word_index = w_wr ? w_ret_off : '0;
  assign fill_data = mem_data_in;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  logic [WIW-1:0] r_crit;
  assign w_iss_off = rot_offset(r_crit, w_iss[WIW-1:0]);
  assign w_ret_off = rot_offset(r_crit, w_ret[WIW-1:0]);
  always_ff @(posedge clk)
    r_crit <= rst ? '0 : w_start ? miss_address[WIW:1] : r_crit;
`else
  assign w_iss_off = w_iss[WIW-1:0];
  assign w_ret_off = w_ret[WIW-1:0];
`endif
  assign w_unused = ^{w_ret_sat, miss_address[WIW:0]};
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_tag <= '0;
    end else if (w_start) begin
      r_state <= FILL;
      r_tag <= miss_address[ADDR_WIDTH-1:WIW+1];
    end else if (w_last)
      r_state <= IDLE;
  fill_counter #(.MAX(BLOCK_WORDS)) u_iss (
    .clk(clk), .rst(rst), .i_clr(w_start), .i_en(fsm_busy), .o_count(w_iss), .o_sat(w_iss_sat)
  );
  fill_counter #(.MAX(BLOCK_WORDS)) u_ret (
    .clk(clk), .rst(rst), .i_clr(w_start), .i_en(w_wr), .o_count(w_ret), .o_sat(w_ret_sat)
  );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized check of cache_fill_fsm against a list-based fill model and a latency-L memory
module tb_cache_fill_fsm;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  localparam int CWF = 1;
`else
  localparam int CWF = 0;
`endif
  logic clk = 0, rst = 1, miss_detected = 0, mem_data_valid = 0;
  logic fsm_busy, mem_en, write_data_array, write_tag_array;
  logic [15:0] miss_address = 0, mem_data_in = 0, mem_addr, fill_data;
  logic [2:0] word_index;
  int total = 0, bad = 0, cyc = 0, lat = 4;
  int pend[$];
  bit armed = 0, m_busy = 0;
  int m_iss = 0, m_ret = 0;
  int m_addr[8], m_idx[8];
  always #5 clk = ~clk;
  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in), .fsm_busy(fsm_busy),
    .mem_en(mem_en), .mem_addr(mem_addr), .write_data_array(write_data_array),
    .write_tag_array(write_tag_array), .word_index(word_index), .fill_data(fill_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic start(input logic [15:0] a);
    int base = a & 16'hFFF0;
    int crit = (a >> 1) & 7;
    for (int n = 0; n < 8; n++) begin
      m_idx[n] = (n + CWF * crit) % 8;
      m_addr[n] = base + 2 * m_idx[n];
    end
    m_busy = 1;
    m_iss = 0;
    m_ret = 0;
  endtask
  task automatic step(input bit r, input bit m, input logic [15:0] a, input bit stray);
    bit v, exp_en, exp_wr;
    @(negedge clk);
    v = 0;
    if (pend.size() > 0 && pend[0] == cyc) begin
      v = 1;
      void'(pend.pop_front());
    end
    rst = r;
    miss_detected = m;
    miss_address = a;
    mem_data_valid = v | stray;
    mem_data_in = 16'($urandom);
    #1;
    exp_en = m_busy && m_iss < 8;
    exp_wr = m_busy && mem_data_valid && m_ret < m_iss;
    if (armed) begin
      chk("busy", fsm_busy, m_busy);
      chk("mem_en", mem_en, exp_en);
      if (exp_en || !m_busy) chk("mem_addr", mem_addr, exp_en ? m_addr[m_iss] : 0);
      chk("wr_data", write_data_array, exp_wr);
      chk("wr_tag", write_tag_array, exp_wr && m_ret == 7);
      if (exp_wr || !m_busy) chk("word_index", word_index, exp_wr ? m_idx[m_ret] : 0);
      chk("fill_data", fill_data, mem_data_in);
    end
    if (exp_en) pend.push_back(cyc + lat);
    if (r) begin
      m_busy = 0;
      m_iss = 0;
      m_ret = 0;
      armed = 1;
    end else if (!m_busy) begin
      if (m) start(a);
    end else begin
      if (m_iss < 8) m_iss++;
      if (exp_wr) begin
        if (m_ret == 7) m_busy = 0;
        m_ret++;
      end
    end
    cyc++;
  endtask
  task automatic drain();
    for (int i = 0; i < 80 && (m_busy || pend.size() > 0); i++) step(0, 0, 0, 0);
    chk("drained", {31'd0, m_busy} | pend.size(), 0);
  endtask
  task automatic fill_check(input logic [15:0] a, input logic [15:0] f0, input logic [15:0] f1);
    int n = 0, k = 0;
    logic [15:0] seen[2] = '{16'hDEAD, 16'hDEAD};
    step(0, 1, a, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, 0);
      if (mem_en && k < 2) begin
        seen[k] = mem_addr;
        k++;
      end
      if (fsm_busy) n++;
      else if (n > 0) break;
    end
    chk("busy_len", n, 8 + lat);
    chk("first_req", seen[0], f0);
    chk("second_req", seen[1], f1);
    drain();
  endtask
  initial begin
    repeat (3) step(1, 0, 0, 0);
    lat = 4;
    fill_check(16'h1236, CWF ? 16'h1236 : 16'h1230, CWF ? 16'h1238 : 16'h1232);
    lat = 3;
    fill_check(16'hFFFE, CWF ? 16'hFFFE : 16'hFFF0, CWF ? 16'hFFF0 : 16'hFFF2);
    lat = 2;
    for (int i = 0; i < 30; i++) step(0, 1, (i == 0) ? 16'h1236 : 16'h4450 + 16'(2 * (i % 8)), 0);
    drain();
    lat = 5;
    step(0, 1, 16'h2222, 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_idle", {fsm_busy, mem_en, write_data_array, write_tag_array}, 0);
    drain();
    fill_check(16'h345A, CWF ? 16'h345A : 16'h3450, CWF ? 16'h345C : 16'h3452);
    repeat (3) step(0, 0, 0, 1);
    chk("stray_idle", fsm_busy, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy && pend.size() == 0) lat = $urandom_range(1, 6);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, 16'($urandom),
           !m_busy && pend.size() == 0 && $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between a direct-mapped cache and the multi-cycle, pipelined main memory (`memory4c`), which replaces the single-cycle `memory1c`/`memory1d` arrays. On a miss the block latches the miss address and issues one read request per 16-bit word of the 16-byte block. It then writes each returned word into the cache data array and writes the tag on the final word. One instance serves the I-cache and one serves the D-cache. An external arbiter grants memory access and is outside this block.

## Interface
- `ADDR_WIDTH`, 16, byte-address width.
- `BLOCK_WORDS`, 8, 16-bit words per cache block; must be a power of two.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `miss_detected` in 1: cache miss; sampled only in IDLE.
- `miss_address` in ADDR_WIDTH: byte address of the missing access; bit 0 is ignored.
- `mem_data_valid` in 1: memory returns one word this cycle, in issue order.
- `mem_data_in` in 16: returned word.
- `fsm_busy` out 1: fill in progress; the cache stalls the pipeline.
- `mem_en` out 1: read request this cycle (`wr` is held 0 by the top level).
- `mem_addr` out ADDR_WIDTH: request byte address.
- `write_data_array` out 1: write `fill_data` into word `word_index` of the latched set.
- `write_tag_array` out 1: write the tag and set the valid bit for the latched set.
- `word_index` out log2(BLOCK_WORDS): word offset within the block for the current data write.
- `fill_data` out 16: equal to `mem_data_in`.

## Operation
- States: IDLE, FILL.
- IDLE → FILL when `miss_detected`=1. On that edge, latch `base` = miss_address with the low log2(BLOCK_WORDS)+1 bits cleared, latch `crit` = miss_address word offset, and clear both counters.
- `miss_detected` asserted while in FILL is ignored; the cache re-presents it after the fill completes.
- Issue counter `iss` runs 0..BLOCK_WORDS.
  - In FILL with `iss`<BLOCK_WORDS: `mem_en`=1 and `mem_addr` = base | (offset(iss) << 1); `iss` increments every cycle, with no backpressure.
- Return counter `ret` runs 0..BLOCK_WORDS-1.
  - In FILL with `mem_data_valid`: `write_data_array`=1, `word_index`=offset(ret), and `ret` increments.
  - On the return where `ret`=BLOCK_WORDS-1: `write_tag_array`=1 in the same cycle, and the state goes to IDLE on the next edge.
- offset(n) = n when the configuration macro is undefined. Counter arithmetic is modulo BLOCK_WORDS; the offset wraps from 7 to 0.
- `mem_data_valid` in IDLE is ignored; it does not cause a write.
- A return arriving before a request has been issued (`ret`≥`iss`) is a protocol error. It is ignored and never occurs with a conforming memory.
- `fsm_busy` = (state==FILL).

## Timing
- Reset values: state=IDLE and all outputs 0, with `fill_data` following its input. Counters, `base` and `crit` are all 0.
- `rst` in mid-fill forces IDLE on that edge and discards in-flight returns. The cache's valid bit for the set is untouched, because the tag is written only on completion.
- With miss at cycle 0: FILL and the first `mem_en` start in cycle 1, and the last request is issued in cycle 8.
- With a memory latency of L cycles, the first write occurs in cycle 1+L and `write_tag_array` in cycle 8+L. The cache sees `fsm_busy` fall in cycle 9+L.
- IDLE lasts at least one cycle between fills. A miss sampled in that cycle starts the next fill.
- Data and tag writes are combinational strobes. The arrays commit them on the next rising edge.

## Configuration
- `CACHE_FILL_CRIT_WORD_FIRST_EN`
  - When defined: offset(n) = (crit + n) mod BLOCK_WORDS. The critical word is requested first and written first.
  - When undefined: offset(n) = n, ascending from word 0, and `crit` is not used.

## Structure
- Package `cache_pkg`:
  - state enum {IDLE, FILL};
  - `BLOCK_WORDS`;
  - `WORD_IDX_W` = log2(BLOCK_WORDS);
  - the offset-rotation function.
- The sub-module `fill_counter` is used twice, for `iss` and `ret`. It is a synchronous-clear, enable-increment counter with a saturation flag.
- The top module holds the state register, the latches and the output decode.

## Test plan
- Miss at 0x1236 with L=4 and the macro off:
  - requests go to 0x1230, 0x1232 … 0x123E in cycles 1–8;
  - writes occur in cycles 5–12 with `word_index` 0..7;
  - `write_tag_array` is asserted in cycle 12 only, and `fsm_busy` is high in cycles 1–12.
- Same miss with the macro on:
  - request order is 0x1236, 0x1238 … 0x123E, 0x1230 … 0x1234;
  - `word_index` sequence is 3,4,5,6,7,0,1,2, showing the wrap.
- Miss at 0xFFFE with the macro on: base is 0xFFF0 and the first request is 0xFFFE, then 0xFFF0. The address must not overflow past 0xFFFF.
- `miss_detected` held high throughout the fill plus a second miss address: only one fill runs. A second fill starts from the cycle after IDLE is reached.
- `rst` asserted in cycle 6 of a fill:
  - next cycle: IDLE with all outputs 0;
  - late `mem_data_valid` pulses produce no writes;
  - a new miss then completes normally.
- Stray `mem_data_valid` in IDLE: `write_data_array` stays 0 and the state stays IDLE.
